// File: rtl/bus_pkg.sv
// Shared bus definitions: register offsets, watchdog state encoding, default fault data.
package bus_pkg;

    localparam logic [7:0]  WD_STATUS          = 8'h00;
    localparam logic [7:0]  WD_FADDR_HI        = 8'h02;
    localparam logic [7:0]  WD_FADDR_LO        = 8'h04;
    localparam logic [7:0]  WD_CTRL            = 8'h06;

    localparam logic [15:0] WD_FAULT_DATA_DFLT = 16'hFFFF;

    typedef enum logic [1:0] {
        WD_IDLE    = 2'd0,
        WD_WAIT    = 2'd1,
        WD_TIMEOUT = 2'd2,
        WD_DONE    = 2'd3
    } wd_state_t;

endpackage

// File: rtl/wd_regs.sv
// Watchdog register slave: status/fault address/control with W1C fault flag.
// Latency: ack one cycle after uds|lds first seen; read data combinational while ack is high.
// Backpressure: none; ack holds until both byte selects drop, one write commit per access.
module wd_regs
    import bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] data_write,
    output logic [15:0] data_read,
    input  logic [7:0]  addr,
    input  logic        uds,
    input  logic        lds,
    input  logic        rw,
    output logic        ack,
    output logic        irq,
    output logic        enable,
    input  logic        fault_set,
    input  logic [31:0] fault_addr_in,
    input  logic        fault_rw_in
);

    logic        fault;
    logic        fault_rw;
    logic        irq_en;
    logic [7:0]  fault_cnt;
    logic [31:0] fault_addr;
    logic        sel;
    logic        wr_stb;
    logic [15:0] rd_dat;

    assign sel    = uds | lds;
    assign wr_stb = sel & ~ack & ~rw;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ack        <= 1'b0;
            fault      <= 1'b0;
            fault_rw   <= 1'b0;
            fault_cnt  <= 8'd0;
            fault_addr <= 32'd0;
            enable     <= 1'b1;
            irq_en     <= 1'b0;
        end else begin
            ack <= sel;
            // A fault landing on the same edge as a W1C clear must not be lost.
            if (fault_set) begin
                fault      <= 1'b1;
                fault_rw   <= fault_rw_in;
                fault_addr <= fault_addr_in;
                if (fault_cnt != 8'hFF)
                    fault_cnt <= fault_cnt + 8'd1;
            end else if (wr_stb && (addr == WD_STATUS) && uds && data_write[15]) begin
                fault <= 1'b0;
            end
            if (wr_stb && (addr == WD_CTRL) && lds) begin
                enable <= data_write[0];
                irq_en <= data_write[1];
            end
        end
    end

    always_comb begin
        rd_dat = 16'd0;
        case (addr)
            WD_STATUS:   rd_dat = {fault, fault_rw, 6'd0, fault_cnt};
            WD_FADDR_HI: rd_dat = fault_addr[31:16];
            WD_FADDR_LO: rd_dat = fault_addr[15:0];
            WD_CTRL:     rd_dat = {14'd0, irq_en, enable};
            default:     rd_dat = 16'd0;
        endcase
    end

    assign data_read = ack ? rd_dat : 16'd0;
    assign irq       = fault & irq_en;

endmodule

// File: rtl/bus_watchdog.sv
// CPU-to-device_mux pass-through that forces a FAULT_DATA ack on a slave that never answers.
// Latency: healthy cycles 0 added cycles; a hung cycle is acked TIMEOUT_CYCLES clocks after AS is sampled.
// Backpressure: none of its own; AS to the mux is withdrawn while the forced ack is held.
module bus_watchdog
    import bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          CNT_W          = 8,
    parameter logic [15:0] FAULT_DATA     = WD_FAULT_DATA_DFLT
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cpu_as,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_rw,
    output logic        cpu_ack,
    output logic [15:0] cpu_read,
    output logic        mux_as,
    input  logic        mux_ack,
    input  logic [15:0] mux_read,
    input  logic [15:0] data_write,
    output logic [15:0] data_read,
    input  logic [7:0]  addr,
    input  logic        uds,
    input  logic        lds,
    input  logic        rw,
    output logic        ack,
    output logic        irq
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    wd_state_t        state;
    wd_state_t        state_nxt;
    logic [CNT_W-1:0] count;
    logic             forced_ack;
    logic             enable;
    logic             fault_set;

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= WD_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!enable) begin
            state_nxt = WD_IDLE;
        end else begin
            case (state)
                WD_IDLE:    if (cpu_as) state_nxt = WD_WAIT;
                // Slave ack beats the timeout even on the final count.
                WD_WAIT:    if (mux_ack)               state_nxt = WD_DONE;
                            else if (!cpu_as)          state_nxt = WD_IDLE;
                            else if (count == CNT_LAST) state_nxt = WD_TIMEOUT;
                WD_TIMEOUT: if (!cpu_as) state_nxt = WD_IDLE;
                WD_DONE:    if (!cpu_as) state_nxt = WD_IDLE;
                default:    state_nxt = WD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count      <= '0;
            forced_ack <= 1'b0;
        end else begin
            count      <= ((state == WD_WAIT) && (state_nxt == WD_WAIT)) ? count + 1'b1 : '0;
            forced_ack <= (state_nxt == WD_TIMEOUT);
        end
    end

    assign fault_set = (state == WD_WAIT) && (state_nxt == WD_TIMEOUT);

    always_comb begin
        mux_as   = cpu_as & (state != WD_TIMEOUT);
        cpu_ack  = mux_ack | forced_ack;
        cpu_read = forced_ack ? FAULT_DATA : mux_read;
    end

    wd_regs u_regs (
        .clk           (clk),
        .reset_n       (reset_n),
        .data_write    (data_write),
        .data_read     (data_read),
        .addr          (addr),
        .uds           (uds),
        .lds           (lds),
        .rw            (rw),
        .ack           (ack),
        .irq           (irq),
        .enable        (enable),
        .fault_set     (fault_set),
        .fault_addr_in (cpu_addr),
        .fault_rw_in   (cpu_rw)
    );

endmodule
